main_control_fsm: RTL and testbench

- Multi-cycle RISC-V main control unit for the non-pipelined datapath.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK for lw, sw, R-type and beq.
- Drives alu_op to the ALU-control decoder and consumes that decoder's invalid-function flag.
- Produces all datapath mux selects, write enables and memory request strobes.
- Waits on a memory ready handshake.
- Enters a sticky trap on an illegal opcode or funct.

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/ctrl_output_decode.sv | 70 +++++++
 rtl/main_control_fsm.sv | 129 ++++++++++++
 tb/tb_main_control_fsm.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V main control unit: states,
// opcodes, datapath select codes, trap causes and the packed control word.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_TRAP     = 4'd9
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_OPCODE  = 2'b01;
    localparam logic [1:0] TRAP_FUNCT   = 2'b10;
    localparam logic [1:0] TRAP_TIMEOUT = 2'b11;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_en;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
        logic       instr_done;
    } ctrl_t;

    // States that sit on the memory handshake and are subject to the stall limit.
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational state -> control-word decode. Mostly Moore; the fetch strobes,
// branch PC enable and store retirement are qualified by mem_ready / zero.
module ctrl_output_decode
    import ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   zero,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src_a  = SRCA_PC;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALU;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_en      = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.adr_src  = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_MEMDATA;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.adr_src    = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXECR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_RS2;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a  = SRCA_RS1;
                ctrl.alu_src_b  = SRCB_RS2;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_en      = zero;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM: state register, next-state logic, memory
// stall watchdog and sticky trap register around the output decoder.
module main_control_fsm
    import ctrl_pkg::*;
#(
    parameter logic [3:0]  RESET_STATE  = 4'd0,
    parameter int unsigned MEM_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       inv_func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_en,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state_dbg
);

    state_t      state_reg, state_next;
    logic        trap_reg;
    logic [1:0]  cause_reg, cause_next;
    logic [31:0] stall_cnt_reg;
    logic        waiting, timeout;
    ctrl_t       ctrl_w, ctrl_out;

    always_comb begin
        state_next = state_reg;
        cause_next = TRAP_NONE;
        waiting    = is_mem_wait(state_reg) && !mem_ready;
        timeout    = (MEM_WAIT_MAX != 0) && waiting &&
                     ((stall_cnt_reg + 32'd1) >= MEM_WAIT_MAX);
        case (state_reg)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_BRANCH:         state_next = S_BEQ;
                    default: begin
                        state_next = S_TRAP;
                        cause_next = TRAP_OPCODE;
                    end
                endcase
            end
            S_MEMADR:   state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECR: begin
                if (inv_func) begin
                    state_next = S_TRAP;
                    cause_next = TRAP_FUNCT;
                end else begin
                    state_next = S_ALUWB;
                end
            end
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default: begin
                // Corrupted encoding: park in the trap rather than wander.
                state_next = S_TRAP;
                cause_next = TRAP_OPCODE;
            end
        endcase
        if (timeout) begin
            state_next = S_TRAP;
            cause_next = TRAP_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= state_t'(RESET_STATE);
            trap_reg      <= 1'b0;
            cause_reg     <= TRAP_NONE;
            stall_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            // Only the first cause is latched; the trap is left solely by reset.
            if (state_reg != S_TRAP && state_next == S_TRAP) begin
                trap_reg  <= 1'b1;
                cause_reg <= cause_next;
            end
            if (state_next != state_reg)
                stall_cnt_reg <= '0;
            else if ((MEM_WAIT_MAX != 0) && waiting)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    ctrl_output_decode u_decode (
        .state     (state_reg),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (ctrl_w)
    );

    // Strobes must drop the moment reset rises, not at the next clock edge.
    assign ctrl_out   = reset ? '0 : ctrl_w;

    assign mem_read   = ctrl_out.mem_read;
    assign mem_write  = ctrl_out.mem_write;
    assign adr_src    = ctrl_out.adr_src;
    assign ir_write   = ctrl_out.ir_write;
    assign pc_en      = ctrl_out.pc_en;
    assign reg_write  = ctrl_out.reg_write;
    assign alu_src_a  = ctrl_out.alu_src_a;
    assign alu_src_b  = ctrl_out.alu_src_b;
    assign result_src = ctrl_out.result_src;
    assign alu_op     = ctrl_out.alu_op;
    assign instr_done = ctrl_out.instr_done;
    assign trap       = trap_reg;
    assign trap_cause = cause_reg;
    assign state_dbg  = state_reg;

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: instruction scripts expand into per-cycle
// expected control words which a single runner compares against two DUTs.
module tb_main_control_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       trap;
        logic [1:0] cause;
        logic       mr, mw, adr, irw, pce, rw;
        logic [1:0] a, b, res, op;
        logic       done;
    } out_t;

    typedef struct {
        logic [6:0] opcode;
        logic       inv_func, zero, mem_ready;
        out_t       e0, e4;
        string      tag;
    } rec_t;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011,
                           RT = 7'b0110011, BQ = 7'b1100011, BAD = 7'b0010011;

    logic       clk = 1'b0, reset = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       inv_func = 1'b0, zero = 1'b0, mem_ready = 1'b0;

    logic mr0, mw0, adr0, irw0, pce0, rw0, done0, trap0;
    logic mr4, mw4, adr4, irw4, pce4, rw4, done4, trap4;
    logic [1:0] a0, b0, res0, op0, c0, a4, b4, res4, op4, c4;
    logic [3:0] st0, st4;
    out_t g0, g4;

    int checks = 0, failures = 0;
    int done_cnt, rw_cnt, mrd_cnt, pce_cnt;
    rec_t q[$];

    always #5 clk = ~clk;

    main_control_fsm #(.RESET_STATE(4'd0), .MEM_WAIT_MAX(0)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .inv_func(inv_func), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mr0), .mem_write(mw0), .adr_src(adr0),
        .ir_write(irw0), .pc_en(pce0), .reg_write(rw0), .alu_src_a(a0), .alu_src_b(b0),
        .result_src(res0), .alu_op(op0), .instr_done(done0), .trap(trap0),
        .trap_cause(c0), .state_dbg(st0)
    );

    main_control_fsm #(.RESET_STATE(4'd0), .MEM_WAIT_MAX(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .inv_func(inv_func), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mr4), .mem_write(mw4), .adr_src(adr4),
        .ir_write(irw4), .pc_en(pce4), .reg_write(rw4), .alu_src_a(a4), .alu_src_b(b4),
        .result_src(res4), .alu_op(op4), .instr_done(done4), .trap(trap4),
        .trap_cause(c4), .state_dbg(st4)
    );

    assign g0 = {st0, trap0, c0, mr0, mw0, adr0, irw0, pce0, rw0, a0, b0, res0, op0, done0};
    assign g4 = {st4, trap4, c4, mr4, mw4, adr4, irw4, pce4, rw4, a4, b4, res4, op4, done4};

    // Expected control words, one per instruction phase, written from the
    // documented encodings.
    function automatic out_t blank(input logic [3:0] st);
        out_t o = '0;
        o.st = st;
        return o;
    endfunction
    function automatic out_t o_fetch(input logic rdy);
        out_t o = blank(4'd0);
        o.mr = 1; o.b = 2'b10; o.res = 2'b10; o.irw = rdy; o.pce = rdy;
        return o;
    endfunction
    function automatic out_t o_decode();
        out_t o = blank(4'd1);
        o.a = 2'b01; o.b = 2'b01;
        return o;
    endfunction
    function automatic out_t o_memadr();
        out_t o = blank(4'd2);
        o.a = 2'b10; o.b = 2'b01;
        return o;
    endfunction
    function automatic out_t o_memread();
        out_t o = blank(4'd3);
        o.mr = 1; o.adr = 1;
        return o;
    endfunction
    function automatic out_t o_memwb();
        out_t o = blank(4'd4);
        o.res = 2'b01; o.rw = 1; o.done = 1;
        return o;
    endfunction
    function automatic out_t o_memwrite(input logic rdy);
        out_t o = blank(4'd5);
        o.mw = 1; o.adr = 1; o.done = rdy;
        return o;
    endfunction
    function automatic out_t o_execr();
        out_t o = blank(4'd6);
        o.a = 2'b10; o.op = 2'b10;
        return o;
    endfunction
    function automatic out_t o_aluwb();
        out_t o = blank(4'd7);
        o.rw = 1; o.done = 1;
        return o;
    endfunction
    function automatic out_t o_beq(input logic z);
        out_t o = blank(4'd8);
        o.a = 2'b10; o.op = 2'b01; o.pce = z; o.done = 1;
        return o;
    endfunction
    function automatic out_t o_trap(input logic [1:0] c);
        out_t o = blank(4'd9);
        o.trap = 1; o.cause = c;
        return o;
    endfunction

    task automatic push2(input string tag, input logic [6:0] op, input logic inv,
                         input logic z, input logic rdy, input out_t e0, input out_t e4);
        rec_t r;
        r.opcode = op; r.inv_func = inv; r.zero = z; r.mem_ready = rdy;
        r.e0 = e0; r.e4 = e4; r.tag = tag;
        q.push_back(r);
    endtask
    task automatic push(input string tag, input logic [6:0] op, input logic inv,
                        input logic z, input logic rdy, input out_t e);
        push2(tag, op, inv, z, rdy, e, e);
    endtask

    task automatic ins_rtype(input logic bad, input int trap_cycles);
        push("rt_fetch", RT, 0, 0, 1, o_fetch(1));
        push("rt_decode", RT, 0, 0, 1, o_decode());
        push("rt_execr", RT, bad, 0, 1, o_execr());
        if (bad)
            for (int i = 0; i < trap_cycles; i++)
                push("rt_trap", RT, 1'(i), 1'(i >> 1), 1'(i), o_trap(2'b10));
        else
            push("rt_aluwb", RT, 0, 0, 1, o_aluwb());
    endtask

    task automatic ins_lw(input int stalls);
        push("lw_fetch", LW, 0, 0, 1, o_fetch(1));
        push("lw_decode", LW, 0, 0, 1, o_decode());
        push("lw_memadr", LW, 0, 0, 1, o_memadr());
        for (int i = 0; i < stalls; i++) push("lw_memread_wait", LW, 0, 0, 0, o_memread());
        push("lw_memread", LW, 0, 0, 1, o_memread());
        push("lw_memwb", LW, 0, 0, 1, o_memwb());
    endtask

    task automatic ins_sw(input int stalls);
        push("sw_fetch", SW, 0, 0, 1, o_fetch(1));
        push("sw_decode", SW, 0, 0, 1, o_decode());
        push("sw_memadr", SW, 0, 0, 1, o_memadr());
        for (int i = 0; i < stalls; i++) push("sw_memwrite_wait", SW, 0, 0, 0, o_memwrite(0));
        push("sw_memwrite", SW, 0, 0, 1, o_memwrite(1));
    endtask

    task automatic ins_beq(input logic z);
        push("beq_fetch", BQ, 0, z, 1, o_fetch(1));
        push("beq_decode", BQ, 0, z, 1, o_decode());
        push("beq_exec", BQ, 0, z, 1, o_beq(z));
    endtask

    task automatic ins_badop(input int trap_cycles);
        logic [6:0] ops [4] = '{LW, SW, RT, BQ};
        push("bad_fetch", BAD, 0, 0, 1, o_fetch(1));
        push("bad_decode", BAD, 0, 0, 1, o_decode());
        for (int i = 0; i < trap_cycles; i++)
            push("bad_trap", ops[i % 4], 1'(i), 1'(i >> 1), 1'(i >> 2), o_trap(2'b01));
    endtask

    task automatic chk(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Entered and left at posedge+1; every record is one clock cycle.
    task automatic run_q();
        rec_t r;
        done_cnt = 0; rw_cnt = 0; mrd_cnt = 0; pce_cnt = 0;
        while (q.size() > 0) begin
            r = q.pop_front();
            opcode = r.opcode; inv_func = r.inv_func; zero = r.zero; mem_ready = r.mem_ready;
            #2;
            chk({r.tag, "_w0"}, g0, r.e0);
            chk({r.tag, "_w4"}, g4, r.e4);
            $display("cyc %s st0=%0d st4=%0d out0=%h", r.tag, st0, st4, g0);
            done_cnt += int'(done0);
            rw_cnt   += int'(rw0);
            mrd_cnt  += int'(mr0 & adr0);
            pce_cnt  += int'(pce0 & (st0 == 4'd8));
            @(posedge clk);
            #1;
        end
    endtask

    // Asynchronous reset: outputs must clear before any clock edge arrives.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, "_async0"}, g0, blank(4'd0));
        chk({tag, "_async4"}, g4, blank(4'd0));
        @(posedge clk);
        #1;
        chk({tag, "_held0"}, g0, blank(4'd0));
        reset = 1'b0;
    endtask

    initial begin
        #1;
        do_reset("reset");

        ins_rtype(0, 0);
        chk_int("rtype_len", q.size(), 4);
        run_q();
        chk_int("rtype_regwrite_cycles", rw_cnt, 1);
        chk_int("rtype_done_pulses", done_cnt, 1);

        ins_lw(3);
        chk_int("lw_stall3_len", q.size(), 8);
        run_q();
        chk_int("lw_memread_cycles", mrd_cnt, 4);
        chk_int("lw_regwrite_cycles", rw_cnt, 1);

        ins_sw(0);
        ins_sw(2);
        chk_int("sw_len", q.size(), 4 + 6);
        run_q();
        chk_int("sw_done_pulses", done_cnt, 2);

        ins_beq(1);
        ins_beq(0);
        chk_int("beq_len", q.size(), 6);
        run_q();
        chk_int("beq_pc_en_cycles", pce_cnt, 1);
        chk_int("beq_done_pulses", done_cnt, 2);

        ins_badop(20);
        run_q();
        chk_int("badop_done_pulses", done_cnt, 0);
        do_reset("trap_reset");

        ins_rtype(1, 5);
        run_q();
        chk_int("invfunc_regwrite_cycles", rw_cnt, 0);
        do_reset("func_reset");

        // Fetch stalls for four cycles: only the watchdog instance traps.
        for (int i = 0; i < 4; i++) push("tmo_fetch_wait", LW, 0, 0, 0, o_fetch(0));
        for (int i = 0; i < 3; i++)
            push2("tmo_after", LW, 0, 0, 0, o_fetch(0), o_trap(2'b11));
        run_q();
        do_reset("tmo_reset");

        // Ready on the fourth cycle beats the watchdog.
        for (int i = 0; i < 3; i++) push("rdy4_fetch_wait", LW, 0, 0, 0, o_fetch(0));
        ins_lw(0);
        run_q();
        chk_int("rdy4_done_pulses", done_cnt, 1);

        // Reset in the middle of a read wait.
        push("mid_fetch", LW, 0, 0, 1, o_fetch(1));
        push("mid_decode", LW, 0, 0, 1, o_decode());
        push("mid_memadr", LW, 0, 0, 1, o_memadr());
        push("mid_memread_wait", LW, 0, 0, 0, o_memread());
        run_q();
        mem_ready = 1'b0;
        do_reset("reset_midwait");

        ins_beq(1);
        run_q();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
